// File: rtl/reduce_and_scheduler.sv
// reduce_and_scheduler
//   Shares one external 8-operand reduce-AND datapath among Port_Num requesters.
//   A requester is granted round-robin for a whole packet. Its words load operand
//   slots a..h. Unused slots stay all-ones so the AND is unaffected. After a burst
//   closes, the captured datapath result is returned on a valid/ready channel.
// Ports
//   clk, reset              clock; synchronous active-high reset
//   req_valid/data/last     per-port word stream (port p data at [p*WIDTH +: WIDTH])
//   req_ready               per-port accept, one-hot or zero
//   dp_a..dp_h, dp_q        operand slots out, combinational datapath result in
//   res_valid/ready         result handshake
//   res_data/port/last      captured q, issuing port, 1 = burst closed by req_last
module reduce_and_scheduler #(
  parameter int Port_Num = 2,
  parameter int WIDTH    = 8,
  localparam int PW      = (Port_Num > 1) ? $clog2(Port_Num) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [Port_Num-1:0]       req_valid,
  input  logic [Port_Num*WIDTH-1:0] req_data,
  input  logic [Port_Num-1:0]       req_last,
  output logic [Port_Num-1:0]       req_ready,
  output logic [WIDTH-1:0]          dp_a,
  output logic [WIDTH-1:0]          dp_b,
  output logic [WIDTH-1:0]          dp_c,
  output logic [WIDTH-1:0]          dp_d,
  output logic [WIDTH-1:0]          dp_e,
  output logic [WIDTH-1:0]          dp_f,
  output logic [WIDTH-1:0]          dp_g,
  output logic [WIDTH-1:0]          dp_h,
  input  logic [WIDTH-1:0]          dp_q,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [WIDTH-1:0]          res_data,
  output logic [PW-1:0]             res_port,
  output logic                      res_last
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_RESP} state_t;

  state_t                r_state;
  logic [7:0][WIDTH-1:0] r_slot;
  logic [2:0]            r_cnt;
  logic [PW-1:0]         r_rr;
  logic [PW-1:0]         r_grant;
  logic                  r_close_last;
  logic [WIDTH-1:0]      r_res_data;
  logic [PW-1:0]         r_res_port;
  logic                  r_res_last;

  logic [PW-1:0]         w_pick;
  logic                  w_found;
  logic [WIDTH-1:0]      w_word;
  logic                  w_valid;
  logic                  w_lastin;
  logic [PW-1:0]         w_rr_next;

  // First valid port at or after the rr pointer, wrapping.
  always_comb begin
    w_pick  = r_rr;
    w_found = 1'b0;
    for (int k = 0; k < Port_Num; k++) begin
      int idx;
      idx = int'(r_rr) + k;
      if (idx >= Port_Num) idx = idx - Port_Num;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = PW'(idx);
      end
    end
  end

  // Granted port's word stream and ready decode.
  always_comb begin
    w_word    = '0;
    w_valid   = 1'b0;
    w_lastin  = 1'b0;
    req_ready = '0;
    for (int p = 0; p < Port_Num; p++) begin
      if (r_grant == PW'(p)) begin
        w_word       = req_data[p*WIDTH +: WIDTH];
        w_valid      = req_valid[p];
        w_lastin     = req_last[p];
        req_ready[p] = (r_state == S_LOAD);
      end
    end
  end

  assign w_rr_next = (r_grant == PW'(Port_Num - 1)) ? '0 : r_grant + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_slot       <= '1;
      r_cnt        <= '0;
      r_rr         <= '0;
      r_grant      <= '0;
      r_close_last <= 1'b0;
      r_res_data   <= '0;
      r_res_port   <= '0;
      r_res_last   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_grant <= w_pick;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_valid) begin
            r_slot[r_cnt] <= w_word;
            r_cnt         <= r_cnt + 3'd1;
            // Burst closes on packet end or once all eight slots are filled.
            if (w_lastin || r_cnt == 3'd7) begin
              r_close_last <= w_lastin;
              r_state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_res_data <= dp_q;
          r_res_port <= r_grant;
          r_res_last <= r_close_last;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            r_slot <= '1;
            r_cnt  <= '0;
            // Packet done: advance rr. Otherwise the same port continues with a new burst.
            if (r_res_last) begin
              r_rr    <= w_rr_next;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dp_a      = r_slot[0];
  assign dp_b      = r_slot[1];
  assign dp_c      = r_slot[2];
  assign dp_d      = r_slot[3];
  assign dp_e      = r_slot[4];
  assign dp_f      = r_slot[5];
  assign dp_g      = r_slot[6];
  assign dp_h      = r_slot[7];
  assign res_valid = (r_state == S_RESP);
  assign res_data  = r_res_data;
  assign res_port  = r_res_port;
  assign res_last  = r_res_last;
endmodule

// File: tb/tb_reduce_and_scheduler.sv
module tb_reduce_and_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0] req_last = '0;
  logic [1:0] req_ready;
  logic [7:0] dp_a, dp_b, dp_c, dp_d, dp_e, dp_f, dp_g, dp_h, dp_q;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic [0:0] res_port;
  logic       res_last;

  always #5 clk = ~clk;

  // External reduce-AND datapath.
  assign dp_q = {7'b0, &{dp_a, dp_b, dp_c, dp_d, dp_e, dp_f, dp_g, dp_h}};

  reduce_and_scheduler #(.Port_Num(2), .WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
    .dp_e(dp_e), .dp_f(dp_f), .dp_g(dp_g), .dp_h(dp_h), .dp_q(dp_q),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_port(res_port), .res_last(res_last)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       port;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  exp_t       m_e;
  logic [8:0] wq0[$];
  logic [8:0] wq1[$];
  int         obs_port[$];
  logic [1:0] hs_seen = '0;
  logic [7:0] m_acc = 8'hFF;
  int         m_cnt = 0;
  int         cyc = 0;
  int         close_cyc = 0;
  logic       prev_rv = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: word handshakes feed the model, result handshakes pop the scoreboard.
  always @(negedge clk) begin
    hs_seen = '0;
    if (reset) begin
      m_acc   = 8'hFF;
      m_cnt   = 0;
      prev_rv = 1'b0;
    end else begin
      chk("req_ready_onehot0", 32'($onehot0(req_ready)), 1);
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          hs_seen[p] = 1'b1;
          m_acc = m_acc & req_data[p*8 +: 8];
          m_cnt++;
          if (req_last[p] || m_cnt == 8) begin
            m_e.data = {7'b0, &m_acc};
            m_e.port = p[0];
            m_e.last = req_last[p];
            sb.push_back(m_e);
            close_cyc = cyc;
            m_acc = 8'hFF;
            m_cnt = 0;
          end
        end
      end
      if (res_valid && !prev_rv) chk("latency", cyc, close_cyc + 2);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) chk("unexpected_res", {31'b0, res_valid}, 0);
        else begin
          m_e = sb.pop_front();
          chk("res_data", {24'b0, res_data}, {24'b0, m_e.data});
          chk("res_port", {31'b0, res_port}, {31'b0, m_e.port});
          chk("res_last", {31'b0, res_last}, {31'b0, m_e.last});
          obs_port.push_back(int'(res_port));
        end
      end
      prev_rv = res_valid;
    end
  end

  // Driver: present queue heads; pop after an observed handshake.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (hs_seen[0] && wq0.size() > 0) void'(wq0.pop_front());
      if (hs_seen[1] && wq1.size() > 0) void'(wq1.pop_front());
      req_valid[0] = (wq0.size() > 0);
      req_valid[1] = (wq1.size() > 0);
      if (wq0.size() > 0) begin req_data[7:0]  = wq0[0][7:0]; req_last[0] = wq0[0][8]; end
      else begin req_data[7:0] = '0; req_last[0] = 1'b0; end
      if (wq1.size() > 0) begin req_data[15:8] = wq1[0][7:0]; req_last[1] = wq1[0][8]; end
      else begin req_data[15:8] = '0; req_last[1] = 1'b0; end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    wq0.delete(); wq1.delete();
    req_valid = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 400 && (wq0.size() > 0 || wq1.size() > 0 || sb.size() > 0 || res_valid); i++)
      @(negedge clk);
    chk({tag, "_drain"}, sb.size() + wq0.size() + wq1.size(), 0);
  endtask

  task automatic wait_resv(string tag);
    for (int i = 0; i < 50 && !res_valid; i++) @(negedge clk);
    chk(tag, {31'b0, res_valid}, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {30'b0, req_ready}, 0);
    chk("rst_res_valid", {31'b0, res_valid}, 0);
    chk("rst_res_data", {24'b0, res_data}, 0);
    chk("rst_res_port", {31'b0, res_port}, 0);
    chk("rst_res_last", {31'b0, res_last}, 0);
    chk("rst_slots", {dp_a, dp_d, dp_e, dp_h}, 32'hFFFFFFFF);
    @(posedge clk); #2 reset = 1'b0;

    // 1) single word FF with last on port0
    @(negedge clk); wq0.push_back({1'b1, 8'hFF});
    drain("t1");

    // 2) port1 FF,FF,FE; slots d..h stay padded
    @(negedge clk);
    wq1.push_back({1'b0, 8'hFF}); wq1.push_back({1'b0, 8'hFF}); wq1.push_back({1'b1, 8'hFE});
    wait_resv("t2_resv");
    chk("t2_abc", {8'h0, dp_a, dp_b, dp_c}, 32'h00FFFFFE);
    chk("t2_pad", {dp_d, dp_e, dp_f, dp_g}, 32'hFFFFFFFF);
    chk("t2_pad_h", {24'b0, dp_h}, 32'hFF);
    drain("t2");

    // 3) round-robin after reset: port0, port1, port0
    do_reset();
    obs_port.delete();
    @(negedge clk);
    wq0.push_back({1'b1, 8'hFF}); wq0.push_back({1'b1, 8'h0F});
    wq1.push_back({1'b1, 8'hF0});
    drain("t3");
    chk("t3_nres", obs_port.size(), 3);
    if (obs_port.size() == 3) begin
      chk("t3_order0", obs_port[0], 0);
      chk("t3_order1", obs_port[1], 1);
      chk("t3_order2", obs_port[2], 0);
    end

    // 4) 10-word packet splits into two bursts
    obs_port.delete();
    @(negedge clk);
    for (int i = 0; i < 10; i++) wq0.push_back({(i == 9), 8'hFF});
    drain("t4");
    chk("t4_nres", obs_port.size(), 2);

    // 5) backpressure: result held stable, no new words accepted
    res_ready = 1'b0;
    @(negedge clk);
    wq1.push_back({1'b1, 8'h7F});
    wq0.push_back({1'b1, 8'hFF});
    wait_resv("t5_resv");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_valid", {31'b0, res_valid}, 1);
      if (sb.size() > 0) chk("t5_data", {24'b0, res_data}, {24'b0, sb[0].data});
      chk("t5_ready", {30'b0, req_ready}, 0);
    end
    res_ready = 1'b1;
    drain("t5");

    // 6) reset during LOAD after 3 words discards the packet
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 5; i++) wq0.push_back({1'b0, 8'hFF});
    for (int i = 0; i < 50 && m_cnt != 3; i++) @(negedge clk);
    chk("t6_three_words", m_cnt, 3);
    @(posedge clk); #2;
    reset = 1'b1;
    wq0.delete(); wq1.delete();
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_slots_lo", {dp_a, dp_b, dp_c, dp_d}, 32'hFFFFFFFF);
    chk("t6_slots_hi", {dp_e, dp_f, dp_g, dp_h}, 32'hFFFFFFFF);
    chk("t6_no_pending", sb.size(), 0);
    @(posedge clk); #2 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_res", {31'b0, res_valid}, 0);
    end
    wq0.push_back({1'b1, 8'hFF});
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
